// File: rtl/recur_scheduler.sv
// recur_scheduler
//   Sequences fetch -> execute -> write_back for the inexact-recursion search
//   engine. Owns the call-stack pointer (sp) and the current call address
//   (cur_addr), issues state-memory reads, drives the one-hot stage enables,
//   and after every write-back picks the next call: descend into a freshly
//   pushed call, resume the same call, or return to the parent.
//
// Ports
//   clk, rst_n        clock (rising edge), synchronous active-low reset
//   start             1-cycle pulse, root call already at addr 0 (IDLE only)
//   abort             drop back to IDLE next cycle, no done pulse
//   ex_done           execute finished (EXEC only)
//   wb_new_call       write_back pushed a new call (WB only)
//   wb_over           write_back finished the current call (WB only)
//   state_rdata       state word {pos[4:0], parent[ADDR_W-1:0], over}
//   rd_en, rd_addr    state-memory read strobe / address (= cur_addr)
//   en_stage          001 fetch, 010 execute, 100 write_back
//   seq_w_addr        push address for write_back (= sp)
//   cur_addr, sp      current call, next free stack slot
//   busy, done        not-IDLE flag, 1-cycle completion pulse
//   overflow          sticky stack-full flag, cleared by next start
//   call_cnt          calls pushed since start, saturating
module recur_scheduler #(
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              ex_done,
  input  logic              wb_new_call,
  input  logic              wb_over,
  input  logic [ADDR_W+5:0] state_rdata,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [2:0]        en_stage,
  output logic [ADDR_W-1:0] seq_w_addr,
  output logic [ADDR_W-1:0] cur_addr,
  output logic [ADDR_W-1:0] sp,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [15:0]       call_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_EXEC, S_WB, S_FIN} state_e;

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RD_LAT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic [ADDR_W-1:0] parent_q, parent_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [ADDR_W-1:0] sp_q, sp_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              rd_en_q, rd_en_d;
  logic [2:0]        en_q, en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Only the parent field of the state word matters here.
  logic unused_rdata;
  assign unused_rdata = ^{state_rdata[ADDR_W+5:ADDR_W+1], state_rdata[0]};

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    parent_d = parent_q;
    cur_d    = cur_q;
    sp_d     = sp_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;

    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          state_d = S_RD;
          cur_d   = '0;
          sp_d    = ADDR_W'(1);
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
        S_RD: begin
          state_d = S_WAIT;
          wait_d  = '0;
        end
        S_WAIT: begin
          if (wait_q == WAIT_LAST) begin
            parent_d = state_rdata[ADDR_W:1];
            state_d  = S_EXEC;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
        S_EXEC: if (ex_done) state_d = S_WB;
        S_WB: begin
          state_d = S_RD;
          // over beats new_call: sp is left alone so a simultaneous push is dropped
          if (wb_over) begin
            if (cur_q == '0) state_d = S_FIN;
            else             cur_d   = parent_q;
          end else if (wb_new_call) begin
            // the all-ones slot is reserved, hitting it counts as overflow
            if (&sp_q) begin
              ovf_d   = 1'b1;
              state_d = S_FIN;
            end else begin
              cur_d = sp_q;
              sp_d  = sp_q + 1'b1;
              if (~&cnt_q) cnt_d = cnt_q + 1'b1;
            end
          end
        end
        S_FIN:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    rd_en_d = (state_d == S_RD);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_FIN);
    case (state_d)
      S_RD, S_WAIT: en_d = 3'b001;
      S_EXEC:       en_d = 3'b010;
      S_WB:         en_d = 3'b100;
      default:      en_d = 3'b000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wait_q   <= '0;
      parent_q <= '0;
      cur_q    <= '0;
      sp_q     <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      rd_en_q  <= 1'b0;
      en_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      parent_q <= parent_d;
      cur_q    <= cur_d;
      sp_q     <= sp_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      rd_en_q  <= rd_en_d;
      en_q     <= en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign rd_en      = rd_en_q;
  assign rd_addr    = cur_q;
  assign en_stage   = en_q;
  assign seq_w_addr = sp_q;
  assign cur_addr   = cur_q;
  assign sp         = sp_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign overflow   = ovf_q;
  assign call_cnt   = cnt_q;

endmodule

// File: tb/tb_recur_scheduler.sv
// Bench for recur_scheduler (ADDR_W=3, RD_LAT=1). The reference model tracks
// the call stack as plain integers plus a parent array that stands in for the
// state memory that write_back would fill.
module tb_recur_scheduler;
  localparam int AW  = 3;
  localparam int LAT = 1;
  localparam int TOP = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst_n, start, abort, ex_done, wb_new_call, wb_over;
  logic [AW+5:0] state_rdata;
  logic          rd_en, busy, done, overflow;
  logic [AW-1:0] rd_addr, seq_w_addr, cur_addr, sp;
  logic [2:0]    en_stage;
  logic [15:0]   call_cnt;

  int checks = 0;
  int failures = 0;

  int m_cur, m_sp, m_cnt;
  bit m_ovf;
  logic [AW-1:0] parent_mem [0:TOP];

  always #5 clk = ~clk;

  recur_scheduler #(.ADDR_W(AW), .RD_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ex_done(ex_done),
    .wb_new_call(wb_new_call), .wb_over(wb_over), .state_rdata(state_rdata),
    .rd_en(rd_en), .rd_addr(rd_addr), .en_stage(en_stage), .seq_w_addr(seq_w_addr),
    .cur_addr(cur_addr), .sp(sp), .busy(busy), .done(done), .overflow(overflow),
    .call_cnt(call_cnt)
  );

  // State memory with one cycle of read latency; data is junk outside the valid slot.
  logic          rv_q;
  logic [AW-1:0] ra_q;
  logic [AW+5:0] junk_q;
  always @(posedge clk) begin
    rv_q   <= rd_en;
    ra_q   <= rd_addr;
    junk_q <= (AW+6)'($urandom);
  end
  assign state_rdata = rv_q ? {junk_q[AW+5:AW+1], parent_mem[ra_q], junk_q[0]} : junk_q;

  task automatic noise();
    ex_done     = 1'($urandom);
    wb_over     = 1'($urandom);
    wb_new_call = 1'($urandom);
    start       = 1'($urandom);
  endtask

  task automatic model_reset();
    m_cur = 0; m_sp = 0; m_cnt = 0; m_ovf = 0;
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the RD cycle.
  task automatic begin_run();
    m_cur = 0; m_sp = 1; m_cnt = 0; m_ovf = 0;
    parent_mem[0] = AW'($urandom);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // One full call starting at the negedge of RD. Ends at the next RD negedge,
  // or after FIN at the first IDLE negedge (finished=1).
  task automatic do_call(input bit over, input bit newc, input int exec_wait, output bit finished);
    bit fin;
    checks++;
    if ({rd_en, en_stage, busy, done} !== 6'b1_001_1_0) begin
      failures++; $display("FAIL rd_ctrl: got %b expected 100110", {rd_en, en_stage, busy, done});
    end
    checks++;
    if ({rd_addr, cur_addr, sp} !== {AW'(m_cur), AW'(m_cur), AW'(m_sp)}) begin
      failures++;
      $display("FAIL rd_ptrs: got rd_addr=%0d cur=%0d sp=%0d expected %0d/%0d/%0d",
               rd_addr, cur_addr, sp, m_cur, m_cur, m_sp);
    end
    checks++;
    if ({call_cnt, overflow} !== {16'(m_cnt), m_ovf}) begin
      failures++;
      $display("FAIL rd_cnt: got call_cnt=%0d overflow=%0d expected %0d/%0d", call_cnt, overflow, m_cnt, m_ovf);
    end
    noise();
    @(negedge clk);
    checks++;
    if ({rd_en, en_stage} !== 4'b0_001) begin
      failures++; $display("FAIL wait_ctrl: got %b expected 0001", {rd_en, en_stage});
    end
    noise();
    @(negedge clk);
    for (int k = 0; k <= exec_wait; k++) begin
      checks++;
      if (en_stage !== 3'b010) begin
        failures++; $display("FAIL exec_stage: got %b expected 010 (cycle %0d)", en_stage, k);
      end
      noise();
      ex_done = (k == exec_wait);
      @(negedge clk);
    end
    checks++;
    if ({en_stage, seq_w_addr, cur_addr} !== {3'b100, AW'(m_sp), AW'(m_cur)}) begin
      failures++;
      $display("FAIL wb_state: got en=%b seq_w_addr=%0d cur=%0d expected 100/%0d/%0d",
               en_stage, seq_w_addr, cur_addr, m_sp, m_cur);
    end
    noise();
    wb_over = over;
    wb_new_call = newc;
    fin = 0;
    if (over) begin
      if (m_cur == 0) fin = 1;
      else m_cur = int'(parent_mem[m_cur]);
    end else if (newc) begin
      if (m_sp == TOP) begin
        m_ovf = 1; fin = 1;
      end else begin
        parent_mem[m_sp] = AW'(m_cur);
        m_cur = m_sp;
        m_sp++;
        if (m_cnt < 65535) m_cnt++;
      end
    end
    @(negedge clk);
    wb_over = 0; wb_new_call = 0; ex_done = 0; start = 0;
    if (fin) begin
      checks++;
      if ({done, busy, en_stage, rd_en, overflow} !== {1'b1, 1'b1, 3'b000, 1'b0, m_ovf}) begin
        failures++;
        $display("FAIL fin_state: got done/busy/en/rd_en/ovf=%b expected %b",
                 {done, busy, en_stage, rd_en, overflow}, {1'b1, 1'b1, 3'b000, 1'b0, m_ovf});
      end
      start = 1'($urandom);
      @(negedge clk);
      start = 0;
      checks++;
      if ({done, busy, en_stage, overflow, sp, cur_addr} !== {1'b0, 1'b0, 3'b000, m_ovf, AW'(m_sp), AW'(m_cur)}) begin
        failures++;
        $display("FAIL idle_after_fin: got done=%0d busy=%0d en=%b ovf=%0d sp=%0d cur=%0d expected 0/0/000/%0d/%0d/%0d",
                 done, busy, en_stage, overflow, sp, cur_addr, m_ovf, m_sp, m_cur);
      end
    end
    finished = fin;
  endtask

  task automatic test_reset();
    rst_n = 0;
    for (int i = 0; i < 3; i++) begin
      start = (i != 1); abort = (i != 0);
      @(negedge clk);
      checks++;
      if ({rd_en, en_stage, busy, done, overflow, cur_addr, sp, call_cnt, rd_addr, seq_w_addr} !== '0) begin
        failures++;
        $display("FAIL reset_outputs: got rd_en=%0d en=%b busy=%0d done=%0d ovf=%0d cur=%0d sp=%0d cnt=%0d expected all 0",
                 rd_en, en_stage, busy, done, overflow, cur_addr, sp, call_cnt);
      end
    end
    start = 0; abort = 0; rst_n = 1;
    model_reset();
    @(negedge clk);
    checks++;
    if ({busy, en_stage, rd_en} !== 5'b0) begin
      failures++; $display("FAIL reset_release_idle: got %b expected 00000", {busy, en_stage, rd_en});
    end
  endtask

  task automatic test_single_call();
    bit f;
    begin_run();
    do_call(1'b1, 1'b0, 0, f);
  endtask

  task automatic test_push_pop();
    bit f;
    begin_run();
    do_call(1'b0, 1'b1, 0, f);
    do_call(1'b1, 1'b0, 1, f);
    do_call(1'b1, 1'b0, 0, f);
  endtask

  task automatic test_over_wins();
    bit f;
    begin_run();
    do_call(1'b0, 1'b1, 0, f);
    do_call(1'b1, 1'b1, 2, f);
    do_call(1'b1, 1'b0, 0, f);
  endtask

  task automatic test_overflow();
    bit f;
    begin_run();
    for (int i = 0; i < TOP - 1; i++) do_call(1'b0, 1'b1, 0, f);
    do_call(1'b0, 1'b1, 0, f);
    begin_run();
    do_call(1'b1, 1'b0, 0, f);
  endtask

  task automatic test_abort();
    bit f;
    begin_run();
    do_call(1'b0, 1'b1, 0, f);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (en_stage !== 3'b010) begin
      failures++; $display("FAIL abort_pre_exec: got %b expected 010", en_stage);
    end
    ex_done = 0; start = 0; abort = 1;
    @(negedge clk);
    abort = 0;
    checks++;
    if ({busy, done, en_stage, rd_en, cur_addr, sp, overflow} !== {6'b0, AW'(m_cur), AW'(m_sp), m_ovf}) begin
      failures++;
      $display("FAIL abort_idle: got busy=%0d done=%0d en=%b rd_en=%0d cur=%0d sp=%0d ovf=%0d expected 0/0/000/0/%0d/%0d/%0d",
               busy, done, en_stage, rd_en, cur_addr, sp, overflow, m_cur, m_sp, m_ovf);
    end
    @(negedge clk);
    checks++;
    if ({done, busy} !== 2'b00) begin
      failures++; $display("FAIL abort_no_done: got done/busy=%b expected 00", {done, busy});
    end
  endtask

  task automatic test_reset_mid_wait();
    begin_run();
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    checks++;
    if ({rd_en, en_stage, busy, done, overflow, cur_addr, sp, call_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_mid_wait: got rd_en=%0d en=%b busy=%0d done=%0d ovf=%0d cur=%0d sp=%0d cnt=%0d expected all 0",
               rd_en, en_stage, busy, done, overflow, cur_addr, sp, call_cnt);
    end
    rst_n = 1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_random();
    bit f, over, newc;
    int r, n;
    for (int ep = 0; ep < 40; ep++) begin
      begin_run();
      f = 0; n = 0;
      while (!f && n < 30) begin
        r = $urandom_range(0, 9);
        over = (r <= 3);
        newc = (r >= 3 && r <= 7);
        do_call(over, newc, $urandom_range(0, 3), f);
        n++;
      end
      if (!f) begin
        abort = 1;
        @(negedge clk);
        abort = 0;
        checks++;
        if ({busy, en_stage, rd_en, done, cur_addr, sp} !== {6'b0, AW'(m_cur), AW'(m_sp)}) begin
          failures++;
          $display("FAIL rand_abort: got busy=%0d en=%b rd_en=%0d done=%0d cur=%0d sp=%0d expected 0/000/0/0/%0d/%0d",
                   busy, en_stage, rd_en, done, cur_addr, sp, m_cur, m_sp);
        end
      end
    end
  endtask

  initial begin
    rst_n = 0; start = 0; abort = 0; ex_done = 0; wb_new_call = 0; wb_over = 0;
    for (int i = 0; i <= TOP; i++) parent_mem[i] = '0;
    model_reset();
    test_reset();
    test_single_call();
    test_push_pop();
    test_over_wins();
    test_overflow();
    test_abort();
    test_reset_mid_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
